// File: rtl/npu_drv_pkg.sv
// -----------------------------------------------------------------------------
// npu_drv_pkg
// Shared types and constants for the NPU host driver.
//   drv_state_e       : driver FSM states
//   PIXEL_W           : width of one pixel / result byte
//   DEFAULT_NUM_BYTES : default row length in pixels
// -----------------------------------------------------------------------------
package npu_drv_pkg;

    localparam int PIXEL_W           = 8;
    localparam int DEFAULT_NUM_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        SEND      = 3'd2,
        GAP       = 3'd3,
        WAIT_DONE = 3'd4
    } drv_state_e;

endpackage

// File: rtl/npu_host_driver_if.sv
// -----------------------------------------------------------------------------
// npu_host_driver_if
// Pin bundle between the host driver and the NPU row-processing controller.
//   start    : one-cycle start pulse (driver -> controller)
//   rx_data  : pixel byte           (driver -> controller)
//   rx_valid : qualifies rx_data    (driver -> controller)
//   tx_data  : result byte          (controller -> driver)
//   done     : one-cycle done pulse, tx_data valid alongside (controller -> driver)
// Modports: master = driver side, slave = controller side.
// -----------------------------------------------------------------------------
interface npu_host_driver_if;
    import npu_drv_pkg::*;

    logic               start;
    logic [PIXEL_W-1:0] rx_data;
    logic               rx_valid;
    logic [PIXEL_W-1:0] tx_data;
    logic               done;

    modport master (output start, output rx_data, output rx_valid,
                    input  tx_data, input done);
    modport slave  (input  start, input rx_data, input rx_valid,
                    output tx_data, output done);
endinterface

// File: rtl/npu_drv_row_buf.sv
// -----------------------------------------------------------------------------
// npu_drv_row_buf
// NUM_BYTES x PIXEL_W register file holding one pixel row.
//   clk, rst         : clock, asynchronous active-high reset (clears all cells)
//   lock             : write lock (driven from busy); writes ignored while high
//   wr_en/addr/data  : write port; addresses >= NUM_BYTES are dropped
//   rd_addr/rd_data  : asynchronous read port
// -----------------------------------------------------------------------------
module npu_drv_row_buf
    import npu_drv_pkg::*;
#(
    parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
    parameter int AW        = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               lock,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    logic [PIXEL_W-1:0] cells [NUM_BYTES];

    // One register per cell; an out-of-range address matches no cell, so
    // such writes fall away without extra decode.
    generate
        for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_cell
            logic [PIXEL_W-1:0] cell_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cell_reg <= '0;
                end else if (wr_en && !lock && (32'(wr_addr) == gi)) begin
                    cell_reg <= wr_data;
                end
            end

            assign cells[gi] = cell_reg;
        end
    endgenerate

    assign rd_data = cells[rd_addr];

endmodule

// File: rtl/npu_host_driver.sv
// -----------------------------------------------------------------------------
// npu_host_driver
// Host-side driver for the NPU controller byte interface. Buffers one row
// written by the host; on go pulses start, streams the row as a
// valid-qualified byte stream (optionally gapped), then waits for done and
// captures the result byte. All outputs are registered.
//   clk, rst            : clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data : host row-buffer write (ignored while busy)
//   go                  : start request (ignored while busy)
//   busy                : transaction in progress
//   npu (master)        : start/rx_data/rx_valid out, tx_data/done in
//   result/result_valid : captured result and its one-cycle strobe
//   timeout_err         : sticky abort flag, cleared by next accepted go
// Optional feature macro: NPU_DRV_TIMEOUT_EN (WAIT_DONE abort after
// TIMEOUT_CYCLES cycles). Undefined: waits forever, timeout_err tied to 0.
// -----------------------------------------------------------------------------
module npu_host_driver
    import npu_drv_pkg::*;
#(
    parameter int NUM_BYTES      = DEFAULT_NUM_BYTES,
    parameter int GAP_CYCLES     = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int AW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [AW-1:0]        wr_addr,
    input  logic [PIXEL_W-1:0]   wr_data,
    input  logic                 go,
    output logic                 busy,
    npu_host_driver_if.master    npu,
    output logic [PIXEL_W-1:0]   result,
    output logic                 result_valid,
    output logic                 timeout_err
);

    drv_state_e         state_reg, state_next;
    logic [AW-1:0]      idx_reg, idx_next;
    logic [GW-1:0]      gap_reg, gap_next;
    logic               busy_reg, busy_next;
    logic               start_reg, start_next;
    logic [PIXEL_W-1:0] rx_data_reg, rx_data_next;
    logic               rx_valid_reg, rx_valid_next;
    logic [PIXEL_W-1:0] result_reg, result_next;
    logic               result_valid_reg, result_valid_next;
    logic [AW-1:0]      rd_addr;
    logic [PIXEL_W-1:0] rd_data;

`ifdef NPU_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_reg, wait_next;
    logic          timeout_err_reg, timeout_err_next;
`endif

    // busy is high exactly when the FSM is outside IDLE, so it doubles as
    // the buffer write lock; a write in the go cycle still lands.
    npu_drv_row_buf #(.NUM_BYTES(NUM_BYTES), .AW(AW)) u_row_buf (
        .clk     (clk),
        .rst     (rst),
        .lock    (busy_reg),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Read address is the byte that will be presented next cycle, so the
    // registered rx_data always lines up with rx_valid.
    assign rd_addr = (state_reg == SEND) ? idx_reg + AW'(1) :
                     (state_reg == GAP)  ? idx_reg : '0;

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        gap_next          = gap_reg;
        busy_next         = busy_reg;
        start_next        = 1'b0;
        rx_valid_next     = 1'b0;
        rx_data_next      = rx_data_reg;
        result_next       = result_reg;
        result_valid_next = 1'b0;
`ifdef NPU_DRV_TIMEOUT_EN
        wait_next         = wait_reg;
        timeout_err_next  = timeout_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (go) begin
                    state_next = START;
                    busy_next  = 1'b1;
                    start_next = 1'b1;
`ifdef NPU_DRV_TIMEOUT_EN
                    timeout_err_next = 1'b0;
`endif
                end
            end
            START: begin
                state_next    = SEND;
                idx_next      = '0;
                rx_valid_next = 1'b1;
                rx_data_next  = rd_data;
            end
            SEND: begin
                if (32'(idx_reg) == NUM_BYTES - 1) begin
                    state_next = WAIT_DONE;
`ifdef NPU_DRV_TIMEOUT_EN
                    wait_next  = '0;
`endif
                end else begin
                    idx_next = idx_reg + AW'(1);
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        gap_next   = '0;
                    end else begin
                        rx_valid_next = 1'b1;
                        rx_data_next  = rd_data;
                    end
                end
            end
            GAP: begin
                if (32'(gap_reg) == GAP_CYCLES - 1) begin
                    state_next    = SEND;
                    rx_valid_next = 1'b1;
                    rx_data_next  = rd_data;
                end else begin
                    gap_next = gap_reg + GW'(1);
                end
            end
            WAIT_DONE: begin
                // done is checked first so it wins over a same-cycle expiry
                if (npu.done) begin
                    state_next        = IDLE;
                    busy_next         = 1'b0;
                    result_next       = npu.tx_data;
                    result_valid_next = 1'b1;
                end
`ifdef NPU_DRV_TIMEOUT_EN
                else if (32'(wait_reg) == TIMEOUT_CYCLES - 1) begin
                    state_next       = IDLE;
                    busy_next        = 1'b0;
                    timeout_err_next = 1'b1;
                end else begin
                    wait_next = wait_reg + TW'(1);
                end
`endif
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            idx_reg          <= '0;
            gap_reg          <= '0;
            busy_reg         <= 1'b0;
            start_reg        <= 1'b0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            gap_reg          <= gap_next;
            busy_reg         <= busy_next;
            start_reg        <= start_next;
            rx_data_reg      <= rx_data_next;
            rx_valid_reg     <= rx_valid_next;
            result_reg       <= result_next;
            result_valid_reg <= result_valid_next;
        end
    end

`ifdef NPU_DRV_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_reg        <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            wait_reg        <= wait_next;
            timeout_err_reg <= timeout_err_next;
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    // No abort path in this build; the expression folds to 0 and only keeps
    // TIMEOUT_CYCLES referenced so both builds share one parameter list.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign busy         = busy_reg;
    assign npu.start    = start_reg;
    assign npu.rx_data  = rx_data_reg;
    assign npu.rx_valid = rx_valid_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;

endmodule

// File: tb/tb_npu_host_driver.sv
// -----------------------------------------------------------------------------
// tb_npu_host_driver
// Two driver instances: dut0 (GAP_CYCLES=0) and dut2 (GAP_CYCLES=2), both
// with TIMEOUT_CYCLES=16. Expected bytes are queued when go is issued and
// popped by per-instance monitors as valid beats appear. The timeout section
// is active only when NPU_DRV_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_npu_host_driver;
    import npu_drv_pkg::*;

    localparam int NB = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en0 = 1'b0, wr_en2 = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       go0 = 1'b0, go2 = 1'b0;
    logic       busy0, busy2, rv0, rv2, te0, te2;
    logic [7:0] result0, result2;

    npu_host_driver_if n0 ();
    npu_host_driver_if n2 ();

    always #5 clk = ~clk;

    npu_host_driver #(.NUM_BYTES(NB), .GAP_CYCLES(0), .TIMEOUT_CYCLES(16)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en0), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go0), .busy(busy0), .npu(n0), .result(result0), .result_valid(rv0),
        .timeout_err(te0));

    npu_host_driver #(.NUM_BYTES(NB), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_addr(wr_addr), .wr_data(wr_data),
        .go(go2), .busy(busy2), .npu(n2), .result(result2), .result_valid(rv2),
        .timeout_err(te2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_asrt = 0;
    int n_fail = 0;
    logic [7:0] row0 [NB];
    logic [7:0] row2 [NB];
    logic [7:0] q0 [$];
    logic [7:0] q2 [$];
    int go0_cyc = 0, go2_cyc = 0;
    int beats0 = 0, beats2 = 0, starts0 = 0, starts2 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitors: one line per received beat, checked against queue and timing
    always @(negedge clk) begin
        if (!rst) begin
            if (n0.start) begin
                starts0++;
                chk("start0_cyc", cyc, go0_cyc + 1);
            end
            if (n0.rx_valid) begin
                if (q0.size() == 0) begin
                    chk("rx0_extra", 32'(q0.size()), 1);
                end else begin
                    logic [7:0] e;
                    e = q0.pop_front();
                    $display("dut0 beat %0d data %02h cyc %0d", beats0, n0.rx_data, cyc);
                    chk("rx0_data", 32'(n0.rx_data), 32'(e));
                    chk("rx0_cyc", cyc, go0_cyc + 2 + beats0);
                    beats0++;
                end
            end
            if (n2.start) begin
                starts2++;
                chk("start2_cyc", cyc, go2_cyc + 1);
            end
            if (n2.rx_valid) begin
                if (q2.size() == 0) begin
                    chk("rx2_extra", 32'(q2.size()), 1);
                end else begin
                    logic [7:0] e;
                    e = q2.pop_front();
                    $display("dut2 beat %0d data %02h cyc %0d", beats2, n2.rx_data, cyc);
                    chk("rx2_data", 32'(n2.rx_data), 32'(e));
                    chk("rx2_cyc", cyc, go2_cyc + 2 + beats2 * 3);
                    beats2++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) tick();
    endtask

    task automatic wr(input bit to0, input bit to2, input int a, input logic [7:0] d);
        wr_en0 = to0;
        wr_en2 = to2;
        wr_addr = a[4:0];
        wr_data = d;
        if (to0) row0[a] = d;
        if (to2) row2[a] = d;
        tick();
        wr_en0 = 1'b0;
        wr_en2 = 1'b0;
    endtask

    task automatic go_0();
        go0 = 1'b1;
        go0_cyc = cyc;
        starts0 = 0;
        beats0 = 0;
        for (int i = 0; i < NB; i++) q0.push_back(row0[i]);
        tick();
        go0 = 1'b0;
        wr_en0 = 1'b0;
        chk("busy0_set", 32'(busy0), 1);
    endtask

    task automatic go_2();
        go2 = 1'b1;
        go2_cyc = cyc;
        starts2 = 0;
        beats2 = 0;
        for (int i = 0; i < NB; i++) q2.push_back(row2[i]);
        tick();
        go2 = 1'b0;
        chk("busy2_set", 32'(busy2), 1);
    endtask

    task automatic done_0(input logic [7:0] tx);
        n0.tx_data = tx;
        n0.done = 1'b1;
        tick();
        n0.done = 1'b0;
        n0.tx_data = 8'h00;
        $display("dut0 done: result %02h valid %0b busy %0b", result0, rv0, busy0);
        chk("rv0", 32'(rv0), 1);
        chk("result0", 32'(result0), 32'(tx));
        chk("busy0_clr", 32'(busy0), 0);
        chk("q0_empty", 32'(q0.size()), 0);
        chk("starts0", starts0, 1);
        tick();
        chk("rv0_pulse", 32'(rv0), 0);
    endtask

    task automatic done_2(input logic [7:0] tx);
        n2.tx_data = tx;
        n2.done = 1'b1;
        tick();
        n2.done = 1'b0;
        n2.tx_data = 8'h00;
        $display("dut2 done: result %02h valid %0b busy %0b", result2, rv2, busy2);
        chk("rv2", 32'(rv2), 1);
        chk("result2", 32'(result2), 32'(tx));
        chk("busy2_clr", 32'(busy2), 0);
        chk("q2_empty", 32'(q2.size()), 0);
        chk("starts2", starts2, 1);
        tick();
        chk("rv2_pulse", 32'(rv2), 0);
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, "_busy"},  32'(busy0), 0);
        chk({tag, "_start"}, 32'(n0.start), 0);
        chk({tag, "_valid"}, 32'(n0.rx_valid), 0);
        chk({tag, "_data"},  32'(n0.rx_data), 0);
        chk({tag, "_res"},   32'(result0), 0);
        chk({tag, "_rv"},    32'(rv0), 0);
        chk({tag, "_te"},    32'(te0), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n0.tx_data = 8'h00; n0.done = 1'b0;
        n2.tx_data = 8'h00; n2.done = 1'b0;
        for (int i = 0; i < NB; i++) begin row0[i] = 8'h00; row2[i] = 8'h00; end

        // Reset state
        repeat (3) tick();
        chk_zero0("rst0");
        chk("rst2_busy", 32'(busy2), 0);
        chk("rst2_valid", 32'(n2.rx_valid), 0);
        chk("rst2_res", 32'(result2), 0);
        rst = 1'b0;
        tick();

        // Fill both rows with 00..1F
        for (int i = 0; i < NB; i++) wr(1'b1, 1'b1, i, 8'(i));

        // Back-to-back stream; go while busy and a locked write are ignored
        go_0();
        wait_cyc(go0_cyc + 5);
        go0 = 1'b1;
        tick();
        go0 = 1'b0;
        wait_cyc(go0_cyc + 10);
        wr_en0 = 1'b1; wr_addr = 5'd3; wr_data = 8'hFF;
        tick();
        wr_en0 = 1'b0;
        wait_cyc(go0_cyc + 43);
        chk("busy0_wait", 32'(busy0), 1);
        done_0(8'hA5);
        chk("beats0", beats0, NB);

        // go and wr_en in the same IDLE cycle: new byte used; buf[3] intact
        wr_en0 = 1'b1; wr_addr = 5'd0; wr_data = 8'h5A; row0[0] = 8'h5A;
        go_0();
        wait_cyc(go0_cyc + 35);
        done_0(8'h3C);

        // Spurious done while idle
        n0.tx_data = 8'h77; n0.done = 1'b1;
        tick();
        n0.done = 1'b0; n0.tx_data = 8'h00;
        chk("spur_rv", 32'(rv0), 0);
        chk("spur_res", 32'(result0), 32'h3C);
        tick();
        chk("spur_res2", 32'(result0), 32'h3C);

        // Gapped stream: each beat separated by two idle cycles
        go_2();
        wait_cyc(go2_cyc + 3);
        chk("gap_idle", 32'(n2.rx_valid), 0);
        wait_cyc(go2_cyc + 98);
        done_2(8'hC3);
        chk("beats2", beats2, NB);

        // Reset during SEND at byte 10
        go_0();
        wait_cyc(go0_cyc + 12);
        chk("pre_rst_valid", 32'(n0.rx_valid), 1);
        chk("pre_rst_data", 32'(n0.rx_data), 32'(row0[10]));
        #1 rst = 1'b1;
        #1 chk_zero0("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        q0.delete();
        q2.delete();
        for (int i = 0; i < NB; i++) begin row0[i] = 8'h00; row2[i] = 8'h00; end
        tick();
        for (int i = 0; i < NB; i++) wr(1'b1, 1'b0, i, 8'(8'h80 + i));
        go_0();
        wait_cyc(go0_cyc + 35);
        done_0(8'hAA);

`ifdef NPU_DRV_TIMEOUT_EN
        // No done: abort after 16 WAIT_DONE cycles
        go_0();
        wait_cyc(go0_cyc + 49);
        chk("to_busy_before", 32'(busy0), 1);
        chk("to_err_before", 32'(te0), 0);
        tick();
        chk("to_busy", 32'(busy0), 0);
        chk("to_err", 32'(te0), 1);
        chk("to_rv", 32'(rv0), 0);
        chk("to_res", 32'(result0), 32'hAA);
        tick();
        chk("to_sticky", 32'(te0), 1);
        go_0();
        chk("to_clear", 32'(te0), 0);
        wait_cyc(go0_cyc + 35);
        done_0(8'h11);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
